inv_add_round_key_stage: RTL

INV_ADD_ROUND_KEY_STAGE -- requirements
Module: inv_add_round_key_stage

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_round_key_store.sv | 34 +++
 rtl/inv_add_round_key_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and the buffer-entry type used by the inverse add-round-key stage.
package aes_pkg;
  localparam int BLOCK_W    = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int NUM_RKEYS  = NUM_ROUNDS + 1;

  typedef logic [3:0] round_t;
  localparam round_t LAST_ROUND = 4'(NUM_ROUNDS);

  typedef struct packed {
    logic [BLOCK_W-1:0] block;
    round_t             round;
    logic               mix_en;
  } entry_t;

  // Decryption skips inv_mix_columns on the first and last rounds.
  function automatic logic mix_en_for(input round_t r);
    return (r != 4'd0) && (r != LAST_ROUND);
  endfunction
endpackage

// File: rtl/aes_round_key_store.sv
// Eleven round-key registers with one write port, one combinational read port and a loaded mask.
module aes_round_key_store
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  round_t             widx,
  input  logic [BLOCK_W-1:0] wkey,
  input  round_t             ridx,
  output logic [BLOCK_W-1:0] rkey,
  output logic               all_loaded
);
  logic [BLOCK_W-1:0]   key_q [NUM_RKEYS];
  logic [NUM_RKEYS-1:0] mask_q;
  logic                 widx_ok;

  assign widx_ok = we && (widx <= LAST_ROUND);

  // Key contents survive reset; only the loaded mask is cleared.
  for (genvar k = 0; k < NUM_RKEYS; k++) begin : g_key
    always_ff @(posedge clk) begin
      if (widx_ok && (widx == 4'(k))) key_q[k] <= wkey;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)     mask_q       <= '0;
    else if (widx_ok) mask_q[widx] <= 1'b1;
  end

  assign rkey       = (ridx <= LAST_ROUND) ? key_q[ridx] : '0;
  assign all_loaded = &mask_q;
endmodule

// File: rtl/inv_add_round_key_stage.sv
// Inverse AddRoundKey pipeline stage: XOR with the selected round key, output register plus one skid entry.
module inv_add_round_key_stage
  import aes_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               key_we_i,
  input  round_t             key_idx_i,
  input  logic [BLOCK_W-1:0] key_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [BLOCK_W-1:0] block_i,
  input  round_t             round_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [BLOCK_W-1:0] block_o,
  output round_t             round_o,
  output logic               mix_en_o,
  output logic               keys_loaded_o,
  output logic               err_o
);
  logic [BLOCK_W-1:0] rkey;
  entry_t             new_e, out_q, skid_q;
  logic               out_v, skid_v, err_q;
  logic               fire_in, fire_out, good_in, bad_in;

  aes_round_key_store u_keys (
    .clk        (clk_i),
    .reset_n    (reset_n_i),
    .we         (key_we_i),
    .widx       (key_idx_i),
    .wkey       (key_i),
    .ridx       (round_i),
    .rkey       (rkey),
    .all_loaded (keys_loaded_o)
  );

  assign ready_o  = keys_loaded_o && !skid_v;
  assign fire_in  = v_i && ready_o;
  assign fire_out = out_v && yumi_i;
  assign good_in  = fire_in && (round_i <= LAST_ROUND);
  assign bad_in   = fire_in && (round_i > LAST_ROUND);

  always_comb begin
    new_e        = '0;
    new_e.block  = block_i ^ rkey;
    new_e.round  = round_i;
    new_e.mix_en = mix_en_for(round_i);
  end

  // ready_o is low whenever skid is occupied, so a skid drain never coincides with an accept.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_v  <= 1'b0;
      out_q  <= '0;
      skid_v <= 1'b0;
      skid_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (bad_in) err_q <= 1'b1;
      if (fire_out) begin
        if (skid_v) begin
          out_q  <= skid_q;
          skid_v <= 1'b0;
        end else if (good_in) begin
          out_q  <= new_e;
        end else begin
          out_v  <= 1'b0;
        end
      end else if (good_in) begin
        if (out_v) begin
          skid_q <= new_e;
          skid_v <= 1'b1;
        end else begin
          out_q  <= new_e;
          out_v  <= 1'b1;
        end
      end
    end
  end

  assign v_o      = out_v;
  assign block_o  = out_q.block;
  assign round_o  = out_q.round;
  assign mix_en_o = out_q.mix_en;
  assign err_o    = err_q;
endmodule
